gsd_accumulate_ctrl: RTL and testbench

- Streaming multi-operand accumulator. Accepts two's-complement operands over a valid/ready input and keeps the running sum in GSD redundant form.
- Performs one carry-free add per accepted beat, so there is no carry propagation in the accumulate loop.
- On the beat flagged last, it converts the GSD sum back to two's complement serially, CHUNK digits per cycle, and presents it on a valid/ready output.
- Sits between operand producers (e.g. a dot-product front end) and binary consumers.
- Instantiates the team's existing binary-to-GSD converter and GSD carry-free adder chain.

---
 rtl/gsd_accumulate_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_gsd_accumulate_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsd_accumulate_ctrl.sv
// Streaming accumulator holding the running sum in GSD redundant form.
// Carry-free add per beat, serial GSD-to-binary conversion on packet end.

module gsd_b2g #(
    parameter int LEN = 16
) (
    input  logic [LEN-1:0]      bin,
    output logic [LEN-1:0][1:0] gsd
);
    always_comb begin
        for (int i = 0; i < LEN; i++)
            gsd[i] = bin[i] ? 2'b01 : 2'b00;
        // The sign bit carries weight -2^(LEN-1).
        if (bin[LEN-1])
            gsd[LEN-1] = 2'b10;
    end
endmodule

module gsd_cfa #(
    parameter int LEN = 16
) (
    input  logic [LEN-1:0][1:0] a,
    input  logic [LEN-1:0][1:0] b,
    output logic [LEN-1:0][1:0] s
);
    function automatic int dv(input logic [1:0] d);
        case (d)
            2'b01:   return 1;
            2'b10:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v > 0)
            return 2'b01;
        else if (v < 0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    int   av, bv, pv, t, w, tp;
    logic ng;

    // ng tells whether the lower position may emit a negative transfer,
    // which selects the transfer/interim pair that keeps each sum digit
    // inside {-1,0,1}.
    always_comb begin
        av = 0;
        bv = 0;
        pv = 0;
        t  = 0;
        w  = 0;
        tp = 0;
        ng = 1'b0;
        s  = '0;
        for (int i = 0; i < LEN; i++) begin
            av = dv(a[i]);
            bv = dv(b[i]);
            pv = av + bv;
            case (pv)
                2: begin
                    t = 1;
                    w = 0;
                end
                -2: begin
                    t = -1;
                    w = 0;
                end
                1: begin
                    t = ng ? 0 : 1;
                    w = ng ? 1 : -1;
                end
                -1: begin
                    t = ng ? -1 : 0;
                    w = ng ? 1 : -1;
                end
                default: begin
                    t = 0;
                    w = 0;
                end
            endcase
            s[i] = enc(w + tp);
            tp   = t;
            ng   = (av < 0) || (bv < 0);
        end
    end
endmodule

module gsd_accumulate_ctrl #(
    parameter int LEN   = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN-1:0]   out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);
    localparam int NCH = LEN / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ACC,
        CONV,
        OUT
    } st_t;

    st_t                  st;
    logic [LEN-1:0][1:0]  acc;
    logic [CNT_W-1:0]     cnt;
    logic [LEN-1:0]       res;
    logic                 brw;
    logic [IW-1:0]        idx;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [LEN-1:0][1:0]   opg;
    logic [LEN-1:0][1:0]   sum;
    logic [CHUNK-1:0][1:0] cdig;
    logic [CHUNK-1:0]      cbits;
    logic                  cbrw;
    logic                  p, n, b;
    int                    base;

    gsd_b2g #(.LEN(LEN)) u_b2g (
        .bin (in_data),
        .gsd (opg)
    );

    gsd_cfa #(.LEN(LEN)) u_cfa (
        .a (acc),
        .b (opg),
        .s (sum)
    );

    // Ripple-borrow conversion of one chunk: bit = parity, borrow when
    // digit minus incoming borrow goes negative.
    always_comb begin
        base  = int'(idx) * CHUNK;
        cdig  = acc[base +: CHUNK];
        cbits = '0;
        p     = 1'b0;
        n     = 1'b0;
        b     = brw;
        for (int i = 0; i < CHUNK; i++) begin
            p        = (cdig[i] == 2'b01);
            n        = (cdig[i] == 2'b10);
            cbits[i] = p ^ n ^ b;
            b        = !p && (n || b);
        end
        cbrw = b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ACC;
            acc         <= '0;
            cnt         <= '0;
            res         <= '0;
            brw         <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (st)
                ACC: begin
                    if (in_valid && in_ready_q) begin
                        acc <= sum;
                        cnt <= (&cnt) ? cnt : cnt + 1'b1;
                        if (in_last) begin
                            st         <= CONV;
                            idx        <= '0;
                            brw        <= 1'b0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    res[base +: CHUNK] <= cbits;
                    brw                <= cbrw;
                    if (idx == IW'(NCH - 1)) begin
                        st          <= OUT;
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc         <= '0;
                        cnt         <= '0;
                        st          <= ACC;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    st <= ACC;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = res;
    assign out_count = cnt;
endmodule

// File: tb/tb_gsd_accumulate_ctrl.sv
// Self-checking bench for gsd_accumulate_ctrl: vector table, random
// packets against an arithmetic model, and multi-cycle corner cases.

module tb_gsd_accumulate_ctrl;
    localparam int L   = 16;
    localparam int NCH = 4;
    localparam int CAP = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_last, out_ready;
    logic [L-1:0] in_data;
    logic         in_ready, out_valid, busy;
    logic [L-1:0] out_data;
    logic [7:0]   out_count;

    logic         v4, l4, r4;
    logic [L-1:0] d4;
    logic         ir4, ov4, b4;
    logic [L-1:0] od4;
    logic [3:0]   oc4;

    always #5 clk = ~clk;

    gsd_accumulate_ctrl #(.LEN(16), .CHUNK(4), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    gsd_accumulate_ctrl #(.LEN(16), .CHUNK(4), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .in_ready  (ir4),
        .in_data   (d4),
        .in_last   (l4),
        .out_valid (ov4),
        .out_ready (r4),
        .out_data  (od4),
        .out_count (oc4),
        .busy      (b4)
    );

    typedef struct {
        int              n;
        logic [3:0][15:0] op;
        logic [15:0]     es;
        int              ec;
    } vec_t;

    vec_t         tab [6];
    logic [L-1:0] pkt [$];
    logic [L-1:0] msum;
    int           mcnt;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        msum = '0;
        mcnt = 0;
    endtask

    // Streams pkt, then waits for the result and checks it vs the model.
    task automatic send_pkt(input bit gaps, input bit rnd);
        int lat;
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    out_ready = rnd ? 1'($urandom) : 1'b0;
                    @(negedge clk);
                end
            end
            in_valid  = 1'b1;
            in_data   = pkt[i];
            in_last   = (i == pkt.size() - 1);
            out_ready = rnd ? 1'($urandom) : 1'b0;
            chk("in_ready_beat", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            msum = msum + pkt[i];
            mcnt = (mcnt < CAP) ? mcnt + 1 : CAP;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("busy_conv", {31'd0, busy}, 32'd1);
        chk("in_ready_conv", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (rnd) begin
                in_valid  = 1'($urandom);
                in_data   = L'($urandom);
                out_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NCH);
        chk("out_data", {16'd0, out_data}, {16'd0, msum});
        chk("out_count", {24'd0, out_count}, mcnt);
    endtask

    task automatic hs();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        model_clear();
    endtask

    initial begin
        int lat;
        tab[0] = '{1, {16'h0, 16'h0, 16'h0, 16'h1234}, 16'h1234, 1};
        tab[1] = '{3, {16'h0, 16'h0007, 16'hFFFD, 16'h0005}, 16'h0009, 3};
        tab[2] = '{2, {16'h0, 16'h0, 16'h0001, 16'h7FFF}, 16'h8000, 2};
        tab[3] = '{2, {16'h0, 16'h0, 16'h8000, 16'h8000}, 16'h0000, 2};
        tab[4] = '{1, {16'h0, 16'h0, 16'h0, 16'h8000}, 16'h8000, 1};
        tab[5] = '{4, {16'h1000, 16'hF000, 16'h8001, 16'h7FFF}, 16'h0000, 4};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        v4 = 1'b0;
        l4 = 1'b0;
        d4 = '0;
        r4 = 1'b0;
        model_clear();
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_count", {24'd0, out_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            pkt.delete();
            for (int i = 0; i < tab[v].n; i++)
                pkt.push_back(tab[v].op[i]);
            send_pkt(1'b0, 1'b0);
            chk("tab_data", {16'd0, out_data}, {16'd0, tab[v].es});
            chk("tab_count", {24'd0, out_count}, tab[v].ec);
            hs();
        end

        for (int r = 0; r < 30; r++) begin
            pkt.delete();
            repeat ($urandom_range(1, 8))
                pkt.push_back(L'($urandom));
            send_pkt(1'b1, 1'b1);
            hs();
        end

        pkt.delete();
        repeat (100) pkt.push_back(16'hFFFF);
        send_pkt(1'b0, 1'b0);
        chk("stream_data", {16'd0, out_data}, 32'h0000FF9C);
        chk("stream_count", {24'd0, out_count}, 32'd100);
        hs();

        pkt.delete();
        repeat (300) pkt.push_back(16'h0001);
        send_pkt(1'b0, 1'b0);
        chk("sat_data", {16'd0, out_data}, 32'h0000012C);
        chk("sat_count", {24'd0, out_count}, 32'd255);
        hs();

        pkt.delete();
        pkt.push_back(16'h0042);
        send_pkt(1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid  = 1'b1;
            in_data   = L'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", {16'd0, out_data}, 32'h00000042);
            chk("bp_out_count", {24'd0, out_count}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_last = 1'b0;
        hs();
        pkt.delete();
        pkt.push_back(16'h0003);
        send_pkt(1'b0, 1'b0);
        chk("after_bp_data", {16'd0, out_data}, 32'h00000003);
        hs();

        in_valid = 1'b1;
        in_data  = 16'h0055;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_out_count", {24'd0, out_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        pkt.delete();
        pkt.push_back(16'h0010);
        pkt.push_back(16'h0020);
        send_pkt(1'b0, 1'b0);
        chk("post_rst_data", {16'd0, out_data}, 32'h00000030);
        chk("post_rst_count", {24'd0, out_count}, 32'd2);
        hs();

        for (int i = 0; i < 20; i++) begin
            v4 = 1'b1;
            d4 = 16'h0001;
            l4 = (i == 19);
            chk("c4_in_ready", {31'd0, ir4}, 32'd1);
            @(negedge clk);
        end
        v4 = 1'b0;
        l4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("c4_latency", lat, NCH);
        chk("c4_data", {16'd0, od4}, 32'h00000014);
        chk("c4_count", {28'd0, oc4}, 32'd15);
        r4 = 1'b1;
        @(negedge clk);
        chk("c4_hs_busy", {31'd0, b4}, 32'd0);
        r4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
